// File: rtl/ram_master_pkg.sv
// Shared types and defaults for the change-detect RAM initiator (ram_master).
package ram_master_pkg;

    localparam int DATA_W             = 32;
    localparam int RAM_MASTER_SIZE    = 1024;
    localparam int RAM_MASTER_TIMEOUT = 16;
    localparam int SETTLE_CYCLES      = 2;

    typedef enum logic [2:0] {
        SETTLE,
        IDLE,
        WAIT_LO,
        WAIT_HI,
        WAIT_SAME,
        DONE
    } ram_master_state_t;

    // SIZE is a power of two, so the modulo reduces to a mask.
    function automatic logic [DATA_W-1:0] wrap_addr(input logic [DATA_W-1:0] addr,
                                                    input int size);
        return addr & DATA_W'(size - 1);
    endfunction

endpackage

// File: rtl/ram_master_if.sv
// CPU request/response port plus the RAM-side bundle driven by ram_master.
interface ram_master_if;
    import ram_master_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wr;
    logic [DATA_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_err;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] mem_addr;
    logic              mem_wr;
    logic              mem_response;
    logic [DATA_W-1:0] mem_out;

    modport master (
        input  req_valid, req_wr, req_addr, req_data, mem_response, mem_out,
        output req_ready, resp_valid, resp_data, resp_err, mem_data, mem_addr, mem_wr
    );

    modport slave (
        output req_valid, req_wr, req_addr, req_data, mem_response, mem_out,
        input  req_ready, resp_valid, resp_data, resp_err, mem_data, mem_addr, mem_wr
    );

endinterface

// File: rtl/ram_master_wdog.sv
// Per-transaction timeout counter; only built when RAM_MASTER_WATCHDOG_EN is defined.
module ram_master_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Fires during the TIMEOUT-th enabled cycle so the abort lands on that edge.
    assign expired = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ram_master.sv
// Single-outstanding initiator for the change-detect RAM handshake.
// Optional timeout abort is compiled in with RAM_MASTER_WATCHDOG_EN.
module ram_master
    import ram_master_pkg::*;
#(
    parameter int SIZE    = RAM_MASTER_SIZE,
    parameter int TIMEOUT = RAM_MASTER_TIMEOUT
) (
    input  logic         clk,
    input  logic         rst_n,
    ram_master_if.master bus
);
    ram_master_state_t state, state_nxt;
    logic [1:0]        cnt;
    logic              accept, capture, abort, expired, same_bundle;
    logic [DATA_W-1:0] addr_wrap;
    logic [DATA_W-1:0] mem_data_p0, mem_addr_p0;
    logic              mem_wr_p0;
    logic [DATA_W-1:0] resp_data_p1;

    assign addr_wrap   = wrap_addr(bus.req_addr, SIZE);
    assign same_bundle = {bus.req_wr, addr_wrap, bus.req_data} ==
                         {mem_wr_p0, mem_addr_p0, mem_data_p0};

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        abort     = 1'b0;
        case (state)
            SETTLE:    if (cnt == 2'(SETTLE_CYCLES - 1)) state_nxt = IDLE;
            IDLE: begin
                if (bus.req_valid) begin
                    accept = 1'b1;
                    // The RAM only reacts to a change; an identical bundle never drops response.
                    state_nxt = same_bundle ? WAIT_SAME : WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!bus.mem_response) begin
                    state_nxt = WAIT_HI;
                end else if (expired) begin
                    abort     = 1'b1;
                    state_nxt = DONE;
                end
            end
            WAIT_HI: begin
                if (bus.mem_response) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end else if (expired) begin
                    abort     = 1'b1;
                    state_nxt = DONE;
                end
            end
            WAIT_SAME: begin
                if (cnt == 2'd1) begin
                    capture   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:      state_nxt = IDLE;
            default:   state_nxt = SETTLE;
        endcase
    end

    // Stage p0: request bundle held toward the RAM; stage p1: captured response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SETTLE;
            cnt          <= '0;
            mem_data_p0  <= '0;
            mem_addr_p0  <= '0;
            mem_wr_p0    <= 1'b0;
            resp_data_p1 <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? 2'd0 : cnt + 2'd1;
            if (accept) begin
                mem_data_p0 <= bus.req_data;
                mem_addr_p0 <= addr_wrap;
                mem_wr_p0   <= bus.req_wr;
            end
            if (capture) begin
                resp_data_p1 <= mem_wr_p0 ? '0 : bus.mem_out;
            end else if (abort) begin
                resp_data_p1 <= '0;
            end
        end
    end

`ifdef RAM_MASTER_WATCHDOG_EN
    logic wdog_clear, wdog_en, resp_err_p1;

    assign wdog_clear = (state == IDLE);
    assign wdog_en    = (state == WAIT_LO) || (state == WAIT_HI);

    ram_master_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wdog_clear),
        .en      (wdog_en),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err_p1 <= 1'b0;
        end else if (capture) begin
            resp_err_p1 <= 1'b0;
        end else if (abort) begin
            resp_err_p1 <= 1'b1;
        end
    end

    assign bus.resp_err = resp_err_p1;
`else
    assign expired      = 1'b0;
    assign bus.resp_err = 1'b0;
`endif

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = (state == DONE);
    assign bus.resp_data  = resp_data_p1;
    assign bus.mem_data   = mem_data_p0;
    assign bus.mem_addr   = mem_addr_p0;
    assign bus.mem_wr     = mem_wr_p0;

endmodule

// File: tb/tb_ram_master.sv
// Bench for ram_master: change-detect RAM model, vector table, random traffic
// against a last-written-value memory model, reset and backpressure sequences.
module tb_ram_master;

    localparam int SIZE    = 1024;
    localparam int TIMEOUT = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_master_if bus ();

    ram_master #(.SIZE(SIZE), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // RAM: a changed bundle drops response; a stable bundle executes and raises it.
    bit [31:0] ram_mem [0:SIZE-1];
    bit [64:0] ram_prev = '0;
    bit [64:0] ram_cur;
    bit        ram_resp = 1'b1;
    bit [31:0] ram_out  = '0;
    bit        stuck_hi = 1'b0;

    assign ram_cur = {bus.mem_wr, bus.mem_addr, bus.mem_data};

    always @(negedge clk) begin
        if (ram_cur != ram_prev) begin
            ram_resp <= 1'b0;
            ram_prev <= ram_cur;
        end else begin
            if (ram_cur[64]) ram_mem[ram_cur[41:32]] <= ram_cur[31:0];
            ram_out  <= ram_cur[64] ? ram_cur[31:0] : ram_mem[ram_cur[41:32]];
            ram_resp <= 1'b1;
        end
    end

    assign bus.mem_response = ram_resp | stuck_hi;
    assign bus.mem_out      = ram_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] model_mem [int];

    function automatic logic [31:0] model_rd(input logic [31:0] addr);
        int a;
        a = int'(addr % 32'(SIZE));
        return model_mem.exists(a) ? model_mem[a] : 32'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_req(input string tag, input bit wr, input logic [31:0] addr,
                          input logic [31:0] data, input int max_k,
                          output int lat, output int pulses,
                          output logic [31:0] rdata, output logic rerr);
        int guard;
        lat    = -1;
        pulses = 0;
        rdata  = '0;
        rerr   = 1'b0;
        guard  = 0;
        @(negedge clk);
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready) begin
            check({tag, " ready_wait"}, 32'(bus.req_ready), 32'd1);
            return;
        end
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_data  = data;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 0; k <= max_k; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 0) begin
                check({tag, " mem_addr"}, bus.mem_addr, addr % 32'(SIZE));
                check({tag, " mem_wr"},   32'(bus.mem_wr), 32'(wr));
                check({tag, " mem_data"}, bus.mem_data, data);
            end
            if (bus.resp_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat   = k;
                    rdata = bus.resp_data;
                    rerr  = bus.resp_err;
                end
            end
        end
        check({tag, " mem_hold"}, bus.mem_addr, addr % 32'(SIZE));
    endtask

    task automatic run_req(input string tag, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [31:0] exp);
        int lat, pulses;
        logic [31:0] rdata;
        logic rerr;
        do_req(tag, wr, addr, data, 3, lat, pulses, rdata, rerr);
        check({tag, " latency"}, 32'(lat), 32'd2);
        check({tag, " pulses"},  32'(pulses), 32'd1);
        check({tag, " data"},    rdata, exp);
        check({tag, " err"},     32'(rerr), 32'd0);
        if (wr) model_mem[int'(addr % 32'(SIZE))] = data;
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat, pulses, mid_pulses, accepts, last_acc, idx;
        bit          acc_pending;
        logic [31:0] rdata, exp, prev_addr, prev_data;
        logic        rerr;
        bit          wr, prev_wr;
        logic [31:0] addr, data;
        logic [31:0] exp_q [$];
        bit          bp_wr   [4];
        logic [31:0] bp_addr [4];
        logic [31:0] bp_data [4];

        vecs[0] = '{1'b1, 32'd5,    32'hDEADBEEF, 32'd0};
        vecs[1] = '{1'b0, 32'd5,    32'd0,        32'hDEADBEEF};
        vecs[2] = '{1'b0, 32'd5,    32'd0,        32'hDEADBEEF};
        vecs[3] = '{1'b1, 32'd1029, 32'h00001234, 32'd0};
        vecs[4] = '{1'b0, 32'd5,    32'd0,        32'h00001234};
        vecs[5] = '{1'b1, 32'd6,    32'hFFFFFFFF, 32'd0};
        vecs[6] = '{1'b1, 32'd6,    32'hFFFFFFFF, 32'd0};
        vecs[7] = '{1'b0, 32'd6,    32'd0,        32'hFFFFFFFF};
        vecs[8] = '{1'b1, 32'd7,    32'd0,        32'd0};
        vecs[9] = '{1'b0, 32'd3077, 32'd0,        32'h00001234};

        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;

        // Reset values and SETTLE window
        repeat (3) @(negedge clk);
        check("rst req_ready",  32'(bus.req_ready), 32'd0);
        check("rst resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst resp_err",   32'(bus.resp_err), 32'd0);
        check("rst resp_data",  bus.resp_data, 32'd0);
        check("rst mem_addr",   bus.mem_addr, 32'd0);
        check("rst mem_data",   bus.mem_data, 32'd0);
        check("rst mem_wr",     32'(bus.mem_wr), 32'd0);
        rst_n = 1'b1;
        check("settle0 req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("settle1 req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check("settle2 req_ready", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            run_req($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp);
        end

        prev_wr   = 1'b0;
        prev_addr = 32'd5;
        prev_data = 32'd0;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                wr = prev_wr; addr = prev_addr; data = prev_data;
            end else begin
                wr   = 1'($urandom_range(0, 1));
                addr = 32'($urandom_range(0, 7)) + 32'd1024 * 32'($urandom_range(0, 3));
                data = $urandom;
            end
            exp = wr ? 32'd0 : model_rd(addr);
            run_req($sformatf("rand%0d", i), wr, addr, data, exp);
            prev_wr = wr; prev_addr = addr; prev_data = data;
        end

`ifdef RAM_MASTER_WATCHDOG_EN
        stuck_hi = 1'b1;
        do_req("wdog", 1'b0, 32'd11, 32'h55, 18, lat, pulses, rdata, rerr);
        stuck_hi = 1'b0;
        check("wdog latency", 32'(lat), 32'(TIMEOUT));
        check("wdog pulses",  32'(pulses), 32'd1);
        check("wdog err",     32'(rerr), 32'd1);
        check("wdog data",    rdata, 32'd0);
        run_req("post_wdog", 1'b0, 32'd5, 32'd0, model_rd(32'd5));
`endif

        // Reset asserted while in WAIT_HI
        mid_pulses = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b0;
        bus.req_addr  = 32'd9;
        bus.req_data  = 32'hA5A5;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        mid_pulses += int'(bus.resp_valid);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst mem_addr",   bus.mem_addr, 32'd0);
        check("midrst mem_data",   bus.mem_data, 32'd0);
        check("midrst mem_wr",     32'(bus.mem_wr), 32'd0);
        check("midrst req_ready",  32'(bus.req_ready), 32'd0);
        @(negedge clk);
        mid_pulses += int'(bus.resp_valid);
        @(negedge clk);
        mid_pulses += int'(bus.resp_valid);
        rst_n = 1'b1;
        check("midrst settle0", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        mid_pulses += int'(bus.resp_valid);
        check("midrst settle1", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        mid_pulses += int'(bus.resp_valid);
        check("midrst settle2", 32'(bus.req_ready), 32'd1);
        check("midrst no_resp", 32'(mid_pulses), 32'd0);
        run_req("post_rst", 1'b0, 32'd5, 32'd0, model_rd(32'd5));

        // Backpressure: req_valid held high across four requests
        bp_wr[0] = 1'b1; bp_addr[0] = 32'd20; bp_data[0] = 32'hCAFE0001;
        bp_wr[1] = 1'b0; bp_addr[1] = 32'd20; bp_data[1] = 32'd0;
        bp_wr[2] = 1'b1; bp_addr[2] = 32'd21; bp_data[2] = 32'hCAFE0002;
        bp_wr[3] = 1'b0; bp_addr[3] = 32'd21; bp_data[3] = 32'd0;
        idx = 0; accepts = 0; pulses = 0; last_acc = -1; acc_pending = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = bp_wr[0];
        bus.req_addr  = bp_addr[0];
        bus.req_data  = bp_data[0];
        for (int c = 0; c < 30; c++) begin
            if (bus.resp_valid) begin
                pulses++;
                if (exp_q.size() > 0) check($sformatf("bp resp%0d", pulses), bus.resp_data, exp_q.pop_front());
                else check("bp extra_resp", 32'(pulses), 32'd4);
            end
            if (acc_pending) begin
                acc_pending = 1'b0;
                idx++;
                if (idx < 4) begin
                    bus.req_wr   = bp_wr[idx];
                    bus.req_addr = bp_addr[idx];
                    bus.req_data = bp_data[idx];
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                accepts++;
                if (last_acc >= 0) check("bp spacing", 32'(c - last_acc), 32'd4);
                last_acc = c;
                exp_q.push_back(bp_wr[idx] ? 32'd0 : model_rd(bp_addr[idx]));
                if (bp_wr[idx]) model_mem[int'(bp_addr[idx] % 32'(SIZE))] = bp_data[idx];
                acc_pending = 1'b1;
            end
            @(negedge clk);
        end
        check("bp accepts", 32'(accepts), 32'd4);
        check("bp pulses",  32'(pulses), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
